rename_unit: RTL and testbench

RENAME_UNIT -- requirements
Module: rename_unit

---
 rtl/rename_unit.sv | 126 ++++++++++++
 tb/tb_rename_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rename_unit.sv
// Register rename stage: RAT lookup, free-list allocation, ready-bit tracking
// with same-cycle CDB bypass, and commit-driven release back to the free list.
module rename_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [$clog2(ARCH_REGS)-1:0] rs1_i,
  input  logic [$clog2(ARCH_REGS)-1:0] rs2_i,
  input  logic [$clog2(ARCH_REGS)-1:0] rd_i,
  input  logic                         rd_we_i,
  output logic                         out_valid_o,
  output logic [$clog2(PHYS_REGS)-1:0] prs1_o,
  output logic [$clog2(PHYS_REGS)-1:0] prs2_o,
  output logic [$clog2(PHYS_REGS)-1:0] prd_o,
  output logic [$clog2(PHYS_REGS)-1:0] old_prd_o,
  output logic                         rs1_rdy_o,
  output logic                         rs2_rdy_o,
  input  logic                         cdb_en_i,
  input  logic [$clog2(PHYS_REGS)-1:0] cdb_tag_i,
  input  logic                         commit_en_i,
  input  logic [$clog2(PHYS_REGS)-1:0] commit_old_prd_i
);

  localparam int PW    = $clog2(PHYS_REGS);
  localparam int DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int IW    = $clog2(DEPTH);

  logic [PW-1:0]        rat [ARCH_REGS];
  logic [PW-1:0]        free_list [DEPTH];
  logic [PHYS_REGS-1:0] ready;
  logic [PHYS_REGS-1:0] ready_nxt;
  logic [IW-1:0]        head;
  logic [IW-1:0]        tail;
  logic [FW-1:0]        count;
  logic                 started;

  logic          accept;
  logic          alloc;
  logic          push;
  logic [PW-1:0] src1;
  logic [PW-1:0] src2;
  logic [PW-1:0] new_prd;
  logic          src1_rdy;
  logic          src2_rdy;

  // started keeps in_ready_o low while reset is held and until the first edge after it.
  assign in_ready_o = started & (count != '0);
  assign accept     = in_valid_i & in_ready_o;
  assign alloc      = accept & rd_we_i & (rd_i != '0);
  assign push       = commit_en_i & (commit_old_prd_i != '0) & (count != FW'(DEPTH));
  assign src1       = rat[rs1_i];
  assign src2       = rat[rs2_i];
  assign new_prd    = free_list[head];
  assign src1_rdy   = ready[src1] | (cdb_en_i & (cdb_tag_i == src1));
  assign src2_rdy   = ready[src2] | (cdb_en_i & (cdb_tag_i == src2));

  // Allocation clears after the CDB set; p0 stays ready regardless.
  always_comb begin
    ready_nxt = ready;
    if (cdb_en_i && (cdb_tag_i != '0)) ready_nxt[cdb_tag_i] = 1'b1;
    if (alloc) ready_nxt[new_prd] = 1'b0;
    ready_nxt[0] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) rat[i] <= PW'(i);
    end else if (alloc) begin
      rat[rd_i] <= new_prd;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) free_list[i] <= PW'(ARCH_REGS + i);
    end else if (push) begin
      free_list[tail] <= commit_old_prd_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ready   <= '1;
      head    <= '0;
      tail    <= '0;
      count   <= FW'(DEPTH);
      started <= 1'b0;
    end else begin
      ready   <= ready_nxt;
      started <= 1'b1;
      if (alloc) head <= (head == IW'(DEPTH - 1)) ? '0 : head + IW'(1);
      if (push)  tail <= (tail == IW'(DEPTH - 1)) ? '0 : tail + IW'(1);
      case ({alloc, push})
        2'b10:   count <= count - FW'(1);
        2'b01:   count <= count + FW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      out_valid_o <= 1'b0;
      prs1_o      <= '0;
      prs2_o      <= '0;
      prd_o       <= '0;
      old_prd_o   <= '0;
      rs1_rdy_o   <= 1'b0;
      rs2_rdy_o   <= 1'b0;
    end else begin
      out_valid_o <= accept;
      prs1_o      <= accept ? src1 : '0;
      prs2_o      <= accept ? src2 : '0;
      prd_o       <= alloc ? new_prd : '0;
      old_prd_o   <= alloc ? rat[rd_i] : '0;
      rs1_rdy_o   <= accept & src1_rdy;
      rs2_rdy_o   <= accept & src2_rdy;
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: directed scenarios plus randomized traffic against a
// queue-based rename model.
module tb_rename_unit;
  localparam int A  = 32;
  localparam int P  = 64;
  localparam int D  = P - A;
  localparam int AW = 5;
  localparam int PW = 6;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [AW-1:0] rs1_i, rs2_i, rd_i;
  logic          rd_we_i;
  logic          out_valid_o;
  logic [PW-1:0] prs1_o, prs2_o, prd_o, old_prd_o;
  logic          rs1_rdy_o, rs2_rdy_o;
  logic          cdb_en_i;
  logic [PW-1:0] cdb_tag_i;
  logic          commit_en_i;
  logic [PW-1:0] commit_old_prd_i;

  rename_unit #(.ARCH_REGS(A), .PHYS_REGS(P)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .rd_we_i(rd_we_i),
    .out_valid_o(out_valid_o), .prs1_o(prs1_o), .prs2_o(prs2_o),
    .prd_o(prd_o), .old_prd_o(old_prd_o),
    .rs1_rdy_o(rs1_rdy_o), .rs2_rdy_o(rs2_rdy_o),
    .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i),
    .commit_en_i(commit_en_i), .commit_old_prd_i(commit_old_prd_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: mapping table, ready flags, free registers as a FIFO queue.
  int m_rat [A];
  bit m_rdy [P];
  int m_fl  [$];
  int m_pool[$];
  bit m_started;

  task automatic m_reset();
    for (int i = 0; i < A; i++) m_rat[i] = i;
    for (int i = 0; i < P; i++) m_rdy[i] = 1'b1;
    m_fl.delete();
    for (int i = A; i < P; i++) m_fl.push_back(i);
    m_pool.delete();
    m_started = 1'b0;
  endtask

  task automatic set_req(input bit v, input int s1, input int s2, input int d, input bit we);
    in_valid_i       = v;
    rs1_i            = AW'(s1);
    rs2_i            = AW'(s2);
    rd_i             = AW'(d);
    rd_we_i          = we;
    cdb_en_i         = 1'b0;
    cdb_tag_i        = '0;
    commit_en_i      = 1'b0;
    commit_old_prd_i = '0;
  endtask

  task automatic cycle();
    int  sz0, e_p1, e_p2, e_pd, e_old;
    bit  exp_ready, acc, alloc, e_r1, e_r2;
    sz0       = m_fl.size();
    exp_ready = m_started && (sz0 != 0);
    check("in_ready", in_ready_o, exp_ready);
    acc   = in_valid_i && exp_ready;
    alloc = acc && rd_we_i && (rd_i != 0);
    e_p1 = 0; e_p2 = 0; e_pd = 0; e_old = 0; e_r1 = 0; e_r2 = 0;
    if (acc) begin
      e_p1 = m_rat[rd_i == rd_i ? rs1_i : 0];
      e_p2 = m_rat[rs2_i];
      e_r1 = m_rdy[e_p1] || (cdb_en_i && cdb_tag_i == e_p1);
      e_r2 = m_rdy[e_p2] || (cdb_en_i && cdb_tag_i == e_p2);
    end
    if (alloc) begin
      e_pd  = m_fl.pop_front();
      e_old = m_rat[rd_i];
    end
    if (cdb_en_i && cdb_tag_i != 0) m_rdy[cdb_tag_i] = 1'b1;
    if (alloc) begin
      m_rat[rd_i] = e_pd;
      m_rdy[e_pd] = 1'b0;
    end
    if (commit_en_i && commit_old_prd_i != 0 && sz0 < D) m_fl.push_back(commit_old_prd_i);
    @(posedge clk_i);
    #1;
    m_started = 1'b1;
    check("out_valid", out_valid_o, acc);
    check("prs1", prs1_o, e_p1);
    check("prs2", prs2_o, e_p2);
    check("prd", prd_o, e_pd);
    check("old_prd", old_prd_o, e_old);
    check("rs1_rdy", rs1_rdy_o, e_r1);
    check("rs2_rdy", rs2_rdy_o, e_r2);
    if (e_old != 0) m_pool.push_back(e_old);
  endtask

  task automatic do_reset();
    set_req(0, 0, 0, 0, 0);
    reset_i = 1'b0;
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_ready", in_ready_o, 0);
    check("rst_prd", prd_o, 0);
    check("rst_prs1", prs1_o, 0);
    m_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  initial begin
    set_req(0, 0, 0, 0, 0);
    #2;
    do_reset();
    set_req(0, 0, 0, 0, 0); cycle();

    // Rename with source equal to destination, then dependent reads.
    set_req(1, 5, 0, 5, 1); cycle();
    check("v1_prs1", prs1_o, 5);
    check("v1_prd", prd_o, 32);
    check("v1_old", old_prd_o, 5);
    check("v1_rdy1", rs1_rdy_o, 1);
    set_req(1, 5, 0, 0, 0); cycle();
    check("v2_prs1", prs1_o, 32);
    check("v2_rdy1", rs1_rdy_o, 0);
    set_req(1, 5, 0, 0, 0); cdb_en_i = 1; cdb_tag_i = 32; cycle();
    check("v3_bypass", rs1_rdy_o, 1);
    set_req(1, 5, 0, 0, 0); cycle();
    check("v4_rdybit", rs1_rdy_o, 1);

    // Drain the free list from reset.
    do_reset();
    set_req(0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < D; i++) begin
      set_req(1, 0, 0, 1 + (i % 31), 1); cycle();
      check("drain_prd", prd_o, 32 + i);
    end
    set_req(0, 0, 0, 0, 0); cycle();
    check("empty_ready", in_ready_o, 0);
    set_req(0, 0, 0, 0, 0); commit_en_i = 1; commit_old_prd_i = 7; cycle();
    check("refill_ready", in_ready_o, 1);
    set_req(1, 0, 0, 4, 1); cycle();
    check("reuse7", prd_o, 7);

    // Commit and request in the same cycle on an empty list.
    set_req(1, 0, 0, 6, 1); commit_en_i = 1; commit_old_prd_i = 9; cycle();
    check("empty_nacc", out_valid_o, 0);
    set_req(1, 0, 0, 6, 1); cycle();
    check("reuse9", prd_o, 9);

    // Non-allocating requests and a null commit.
    set_req(0, 0, 0, 0, 0); commit_en_i = 1; commit_old_prd_i = 40; cycle();
    set_req(0, 0, 0, 0, 0); commit_en_i = 1; commit_old_prd_i = 41; cycle();
    set_req(1, 3, 4, 0, 1); cycle();
    set_req(1, 0, 0, 3, 0); cycle();
    set_req(0, 0, 0, 0, 0); commit_en_i = 1; commit_old_prd_i = 0; cycle();
    set_req(1, 0, 0, 8, 1); cycle();
    check("noalloc_prd", prd_o, 40);

    // One entry left: allocate and free together.
    set_req(1, 0, 0, 9, 1); commit_en_i = 1; commit_old_prd_i = 42; cycle();
    check("swap_prd", prd_o, 41);
    check("swap_ready", in_ready_o, 1);
    set_req(1, 0, 0, 10, 1); cycle();
    check("swap_next", prd_o, 42);
    check("swap_empty", in_ready_o, 0);

    // Randomized traffic; commits retire previously displaced mappings.
    for (int n = 0; n < 1500; n++) begin
      set_req($urandom_range(0, 3) != 0, $urandom_range(0, A - 1), $urandom_range(0, A - 1),
              $urandom_range(0, A - 1), $urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) begin
        cdb_en_i  = 1'b1;
        cdb_tag_i = PW'($urandom_range(0, P - 1));
      end
      if (m_pool.size() > 0 && $urandom_range(0, 2) != 0) begin
        commit_en_i      = 1'b1;
        commit_old_prd_i = PW'(m_pool.pop_front());
      end
      cycle();
    end

    // Reset in the middle of an in-flight result.
    do_reset();
    set_req(0, 0, 0, 0, 0); cycle();
    set_req(1, 2, 3, 4, 1); cycle();
    check("pre_rst_valid", out_valid_o, 1);
    do_reset();
    set_req(0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < A; i++) begin
      set_req(1, i, (i + 1) % A, 0, 0); cycle();
      check("ident_prs1", prs1_o, i);
    end
    set_req(0, 0, 0, 0, 0); commit_en_i = 1; commit_old_prd_i = 50; cycle();
    for (int i = 0; i < D; i++) begin
      set_req(1, 0, 0, 1 + (i % 31), 1); cycle();
      check("full_prd", prd_o, 32 + i);
    end
    set_req(0, 0, 0, 0, 0); cycle();
    check("full_empty", in_ready_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
